// File: rtl/logistic_engine_multi.sv
// logistic_engine_multi
//   N-channel logistic-map iterator, x' = mu*x*(1-x), unsigned fixed point.
//   x is Q1.FRAC_W (XW = FRAC_W+1 bits), mu is Q2.FRAC_W (MU_W bits).
//   One pipelined multiplier is shared by all channels, which are served
//   round-robin from channel 0. A start/done job runs `times` iterations.
// Ports
//   CLK, RST     clock, synchronous active-high reset
//   start        one-cycle job request, only honoured while idle
//   abort        stops a running job (no done / iter_valid pulse)
//   mu, times    growth rate and iteration count, latched on accepted start
//   seeds        initial x per channel, channel k at [k*XW +: XW]
//   busy         high while a job is running
//   done         one-cycle pulse at job completion
//   iter_valid   one-cycle pulse, x_out holds a complete iteration
//   iter_cnt     iterations completed in the current job
//   x_out        current x per channel, packed like seeds
module logistic_engine_multi #(
  parameter int FRAC_W   = 16,
  parameter int MU_W     = 18,
  parameter int N_CH     = 7,
  parameter int ITER_W   = 9,
  parameter int MULT_LAT = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         start,
  input  logic                         abort,
  input  logic [MU_W-1:0]              mu,
  input  logic [ITER_W-1:0]            times,
  input  logic [N_CH*(FRAC_W+1)-1:0]   seeds,
  output logic                         busy,
  output logic                         done,
  output logic                         iter_valid,
  output logic [ITER_W-1:0]            iter_cnt,
  output logic [N_CH*(FRAC_W+1)-1:0]   x_out
);

  localparam int XW  = FRAC_W + 1;
  localparam int PW  = 2 * MU_W;
  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int WCW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  localparam logic [XW-1:0] ONE     = XW'(1) << FRAC_W;
  localparam logic [PW-1:0] SAT_LIM = PW'(1) << (2 * FRAC_W);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_M1       = 3'd1;
  localparam logic [2:0] S_W1       = 3'd2;
  localparam logic [2:0] S_M2       = 3'd3;
  localparam logic [2:0] S_W2       = 3'd4;
  localparam logic [2:0] S_WB       = 3'd5;
  localparam logic [2:0] S_ITER_END = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  logic [2:0]        state_r, state_nxt_s;
  logic [MU_W-1:0]   mu_r;
  logic [ITER_W-1:0] times_r;
  logic [ITER_W-1:0] iter_cnt_r;
  logic [CHW-1:0]    ch_r;
  logic [WCW-1:0]    wcnt_r;
  logic [MU_W-1:0]   term_r;
  logic [XW-1:0]     y_r;
  logic [XW-1:0]     x_r [N_CH];
  logic [PW-1:0]     pipe_r [MULT_LAT];
  logic [MU_W-1:0]   op_a_s, op_b_s;
  logic [PW-1:0]     prod_s;
  logic              wcnt_last_s, ch_last_s;
  logic              busy_r, done_r, iter_valid_r;

  // Seeds above ONE are outside the map's domain and are pinned to ONE.
  function automatic logic [XW-1:0] clamp_x(input logic [XW-1:0] v);
    if (v > ONE) begin
      return ONE;
    end else begin
      return v;
    end
  endfunction

  assign prod_s      = pipe_r[MULT_LAT-1];
  assign wcnt_last_s = (wcnt_r == WCW'(MULT_LAT - 1));
  assign ch_last_s   = (ch_r == CHW'(N_CH - 1));

  // Multiplier operand select: x*(ONE-x) in M1, mu*term in M2, zero otherwise.
  always_comb begin
    op_a_s = '0;
    op_b_s = '0;
    case (state_r)
      S_M1: begin
        op_a_s = MU_W'(x_r[ch_r]);
        op_b_s = MU_W'(ONE - x_r[ch_r]);
      end
      S_M2: begin
        op_a_s = mu_r;
        op_b_s = term_r;
      end
      default: begin
        op_a_s = '0;
        op_b_s = '0;
      end
    endcase
  end

  // Free-running multiplier pipeline; never stalled, results picked at W1/W2 end.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < MULT_LAT; i++) pipe_r[i] <= '0;
    end else begin
      pipe_r[0] <= PW'(op_a_s) * PW'(op_b_s);
      for (int i = 1; i < MULT_LAT; i++) pipe_r[i] <= pipe_r[i-1];
    end
  end

  // Next-state logic; abort returns any active state to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nxt_s = (times == {ITER_W{1'b0}}) ? S_DONE : S_M1;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_M1:  state_nxt_s = abort ? S_IDLE : S_W1;
      S_W1: begin
        if (abort) begin
          state_nxt_s = S_IDLE;
        end else if (wcnt_last_s) begin
          state_nxt_s = S_M2;
        end else begin
          state_nxt_s = S_W1;
        end
      end
      S_M2:  state_nxt_s = abort ? S_IDLE : S_W2;
      S_W2: begin
        if (abort) begin
          state_nxt_s = S_IDLE;
        end else if (wcnt_last_s) begin
          state_nxt_s = S_WB;
        end else begin
          state_nxt_s = S_W2;
        end
      end
      S_WB: begin
        if (abort) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = ch_last_s ? S_ITER_END : S_M1;
        end
      end
      S_ITER_END: begin
        // iter_cnt_r already counts the iteration that just finished
        if (abort) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = (iter_cnt_r == times_r) ? S_DONE : S_M1;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Datapath and registered status; status flags are decoded from the next state
  // so they line up with the state they describe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= S_IDLE;
      mu_r         <= '0;
      times_r      <= '0;
      iter_cnt_r   <= '0;
      ch_r         <= '0;
      wcnt_r       <= '0;
      term_r       <= '0;
      y_r          <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      iter_valid_r <= 1'b0;
      for (int k = 0; k < N_CH; k++) x_r[k] <= '0;
    end else begin
      state_r      <= state_nxt_s;
      busy_r       <= (state_nxt_s != S_IDLE) && (state_nxt_s != S_DONE);
      done_r       <= (state_nxt_s == S_DONE);
      iter_valid_r <= (state_nxt_s == S_ITER_END);
      case (state_r)
        S_IDLE: begin
          if (start) begin
            mu_r       <= mu;
            times_r    <= times;
            iter_cnt_r <= '0;
            ch_r       <= '0;
            for (int k = 0; k < N_CH; k++) x_r[k] <= clamp_x(seeds[k*XW +: XW]);
          end
        end
        S_M1, S_M2: wcnt_r <= '0;
        S_W1: begin
          if (wcnt_last_s) begin
            term_r <= prod_s[2*FRAC_W+1:FRAC_W];
          end
          wcnt_r <= wcnt_r + WCW'(1);
        end
        S_W2: begin
          if (wcnt_last_s) begin
            y_r <= (prod_s >= SAT_LIM) ? ONE : prod_s[2*FRAC_W:FRAC_W];
          end
          wcnt_r <= wcnt_r + WCW'(1);
        end
        S_WB: begin
          // An aborted write-back leaves the channel at its previous value.
          if (!abort) begin
            x_r[ch_r] <= y_r;
            if (ch_last_s) begin
              iter_cnt_r <= iter_cnt_r + ITER_W'(1);
            end else begin
              ch_r <= ch_r + CHW'(1);
            end
          end
        end
        S_ITER_END: ch_r <= '0;
        default: begin
          ch_r <= ch_r;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign iter_valid = iter_valid_r;
  assign iter_cnt   = iter_cnt_r;

  for (genvar g = 0; g < N_CH; g++) begin : g_xout
    assign x_out[g*XW +: XW] = x_r[g];
  end

endmodule

// File: tb/tb_logistic_engine_multi.sv
// Directed bench for logistic_engine_multi with a cycle-accurate reference
// model computed from the job timing rules and plain integer arithmetic.
module tb_logistic_engine_multi;
  localparam int FRAC_W = 16, MU_W = 18, N_CH = 7, ITER_W = 9, MULT_LAT = 2;
  localparam int XW = FRAC_W + 1;
  localparam int C = 3 + 2 * MULT_LAT;  // cycles per channel
  localparam int P = N_CH * C + 1;      // cycles per iteration
  localparam int MAXT = 8;
  localparam logic [XW-1:0] ONE = 17'h10000;

  logic CLK = 1'b0, RST, start, abort;
  logic [MU_W-1:0] mu;
  logic [ITER_W-1:0] times;
  logic [N_CH*XW-1:0] seeds, x_out;
  logic busy, done, iter_valid;
  logic [ITER_W-1:0] iter_cnt;

  int total = 0, bad = 0;

  logistic_engine_multi #(.FRAC_W(FRAC_W), .MU_W(MU_W), .N_CH(N_CH),
                          .ITER_W(ITER_W), .MULT_LAT(MULT_LAT)) dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort), .mu(mu), .times(times),
    .seeds(seeds), .busy(busy), .done(done), .iter_valid(iter_valid),
    .iter_cnt(iter_cnt), .x_out(x_out));

  always #5 CLK = ~CLK;

  function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // One logistic step from the arithmetic definition.
  function automatic logic [XW-1:0] lstep(input logic [MU_W-1:0] m, input logic [XW-1:0] x);
    longint unsigned t, p;
    t = (longint'(x) * (longint'(ONE) - longint'(x))) >> FRAC_W;
    p = longint'(m) * t;
    if (p >= (64'd1 << (2 * FRAC_W))) return ONE;
    else return XW'(p >> FRAC_W);
  endfunction

  // Reference model state: job-relative cycle number and per-iteration values.
  bit m_active = 1'b0, m_abort = 1'b0;
  int m_c = 0, m_ca = 0, m_times = 0;
  logic [XW-1:0] xs [0:MAXT][N_CH];

  always @(posedge CLK) begin : model
    int dc;
    bit idle;
    logic [XW-1:0] s;
    dc = 1 + m_times * P;
    idle = !m_active || (m_c > dc) || (m_abort && m_c > m_ca);
    if (RST) begin
      m_active = 1'b0; m_abort = 1'b0; m_c = 0;
    end else if (idle && start) begin
      m_active = 1'b1; m_abort = 1'b0; m_c = 1; m_times = int'(times);
      for (int ch = 0; ch < N_CH; ch++) begin
        s = seeds[ch*XW +: XW];
        xs[0][ch] = (s > ONE) ? ONE : s;
        for (int k = 1; k <= MAXT; k++) xs[k][ch] = lstep(mu, xs[k-1][ch]);
      end
    end else if (m_active) begin
      if (!idle && abort && !m_abort) begin
        m_abort = 1'b1; m_ca = m_c;
      end
      m_c++;
    end
  end

  always @(negedge CLK) begin : compare
    int dc, e, n, cnt;
    bit live, ev, ed, eb;
    logic [N_CH*XW-1:0] ex;
    if (!m_active) begin
      chk("idle_busy", busy, 0); chk("idle_done", done, 0);
      chk("idle_ivalid", iter_valid, 0); chk("idle_cnt", iter_cnt, 0);
      chk("idle_x", x_out, 0);
    end else begin
      dc = 1 + m_times * P;
      if (m_abort) e = (m_c < m_ca) ? m_c : m_ca;
      else e = (m_c < dc) ? m_c : dc;
      live = !(m_abort && m_c > m_ca);
      for (int ch = 0; ch < N_CH; ch++) begin
        n = 0;
        for (int k = 1; k <= m_times; k++)
          if ((k - 1) * P + (ch + 1) * C + 1 <= e) n = k;
        ex[ch*XW +: XW] = xs[n][ch];
      end
      cnt = 0;
      for (int k = 1; k <= m_times; k++) if (k * P <= e) cnt++;
      ev = live && (m_c % P == 0) && (m_c / P >= 1) && (m_c / P <= m_times);
      ed = live && (m_c == dc);
      eb = live && (m_c >= 1) && (m_c < dc);
      chk("busy", busy, eb); chk("done", done, ed); chk("iter_valid", iter_valid, ev);
      chk("iter_cnt", iter_cnt, cnt); chk("x_out", x_out, ex);
    end
  end

  // Start a job and watch it for up to max_cyc cycles; optionally interfere.
  task automatic run_job(input logic [MU_W-1:0] m, input int t, input logic [N_CH*XW-1:0] s,
                         input bit ab_with_start, input int intr_cyc, input int abort_cyc,
                         input int max_cyc, output int dcyc, output int nv);
    @(posedge CLK); #1;
    mu = m; times = ITER_W'(t); seeds = s; start = 1'b1; abort = ab_with_start;
    dcyc = -1; nv = 0;
    for (int k = 1; k <= max_cyc; k++) begin
      @(posedge CLK); #1;
      start = (k == intr_cyc);
      abort = (k == abort_cyc);
      if (k == intr_cyc) begin
        mu = 18'h20000; times = 9'd3; seeds = '0;
      end
      @(negedge CLK);
      if (iter_valid) nv++;
      if (done) begin
        dcyc = k;
        break;
      end
    end
    start = 1'b0; abort = 1'b0;
  endtask

  initial begin
    int dcyc, nv;
    RST = 1'b1; start = 1'b0; abort = 1'b0; mu = '0; times = '0; seeds = '0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_x", x_out, 0); chk("rst_busy", busy, 0);

    // Fixed point of mu=2: x stays at 0.5
    run_job(18'h20000, 3, {7{17'h08000}}, 1'b0, 0, 0, 400, dcyc, nv);
    chk("t1_done_cyc", dcyc, 151); chk("t1_nvalid", nv, 3);
    chk("t1_x", x_out, {7{17'h08000}}); chk("t1_cnt", iter_cnt, 3);

    // mu=3: 0.5 -> 0.75 -> 0.5625
    chk("t2_model_it1", lstep(18'h30000, 17'h08000), 17'h0C000);
    run_job(18'h30000, 2, {7{17'h08000}}, 1'b0, 0, 0, 300, dcyc, nv);
    chk("t2_done_cyc", dcyc, 101); chk("t2_x0", x_out[0 +: XW], 17'h09000);
    chk("t2_cnt", iter_cnt, 2); chk("t2_nvalid", nv, 2);

    // Boundary seeds with mu just under 4
    run_job(18'h3FFFF, 1, {{4{17'h08000}}, 17'h1FFFF, 17'h10000, 17'h00000},
            1'b0, 0, 0, 100, dcyc, nv);
    chk("t3_ch0", x_out[0*XW +: XW], 17'h0); chk("t3_ch1", x_out[1*XW +: XW], 17'h0);
    chk("t3_ch2", x_out[2*XW +: XW], 17'h0); chk("t3_ch3", x_out[3*XW +: XW], 17'h0FFFF);

    // times=0 with abort alongside start: start wins, done next cycle
    run_job(18'h30000, 0, {{4{17'h08000}}, 17'h1FFFF, 17'h10000, 17'h04000},
            1'b1, 0, 0, 10, dcyc, nv);
    chk("t4_done_cyc", dcyc, 1); chk("t4_nvalid", nv, 0);
    chk("t4_clamp", x_out[2*XW +: XW], 17'h10000); chk("t4_ch0", x_out[0 +: XW], 17'h04000);

    // start while busy is ignored
    run_job(18'h30000, 1, {7{17'h08000}}, 1'b0, 10, 0, 100, dcyc, nv);
    chk("t5_done_cyc", dcyc, 51); chk("t5_x", x_out, {7{17'h0C000}});

    // abort in W2 of channel 3 (cycle 26)
    run_job(18'h30000, 2, {7{17'h08000}}, 1'b0, 0, 26, 60, dcyc, nv);
    chk("t5_no_done", dcyc, -1); chk("t5_no_valid", nv, 0);
    chk("t5_abort_x", x_out, {{4{17'h08000}}, {3{17'h0C000}}});
    chk("t5_abort_cnt", iter_cnt, 0); chk("t5_abort_busy", busy, 0);

    // RST during W1 of channel 0, then a clean job
    run_job(18'h30000, 2, {7{17'h08000}}, 1'b0, 0, 0, 2, dcyc, nv);
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    chk("t6_rst_x", x_out, 0); chk("t6_rst_busy", busy, 0); chk("t6_rst_cnt", iter_cnt, 0);
    run_job(18'h30000, 1, {7{17'h04000}}, 1'b0, 0, 0, 100, dcyc, nv);
    chk("t6_done_cyc", dcyc, 51); chk("t6_x", x_out, {7{17'h09000}});

    @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
